uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, core clocks per UART bit (50 MHz / 115200); legal range 8..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, receive FIFO entries; power of two, 2..16.
REQ-003 clk_i  input  1  core clock; all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 i_uart_rx  input  1  serial line, asynchronous to clk_i, idle high.
REQ-006 o_rx_data  output  8  byte at FIFO head; valid only while o_rx_valid=1.
REQ-007 o_rx_valid  output  1  FIFO non-empty.
REQ-008 i_rx_ready  input  1  consumer pop; a byte pops on a cycle with o_rx_valid=1 and i_rx_ready=1.
REQ-009 o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 o_overrun  output  1  one-cycle pulse: completed byte dropped, FIFO full.
REQ-011 o_parity_err  output  1  one-cycle pulse: parity mismatch; tied 0 when parity is compiled out.

Function
REQ-012 i_uart_rx shall pass a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 FSM states: IDLE, START, DATA, PARITY (only with macro), STOP, BREAK.
REQ-014 IDLE: synchronized high-to-low transition -> START with bit counter cleared and clock counter = 0.
REQ-015 START: at count CLKS_PER_BIT/2 (integer division), line sampled; low -> DATA, counter reset; high -> IDLE (false start, no flags).
REQ-016 DATA: sample every CLKS_PER_BIT clocks (mid-bit); 8 bits, LSB first into shift register; after bit 7 -> PARITY or STOP.
REQ-017 STOP: sample after CLKS_PER_BIT; high -> push byte, -> IDLE same cycle (back-to-back frames with zero idle accepted).
REQ-018 STOP sample low -> o_frame_err pulse, byte discarded, -> BREAK; BREAK waits for synchronized line high, then -> IDLE.
REQ-019 Push latency: o_rx_valid=1 and o_rx_data valid the cycle after stop-bit sample when FIFO was empty.
REQ-020 FIFO: first-word-fall-through, FIFO_DEPTH entries, pointer wrap at depth; count width clog2(FIFO_DEPTH)+1.
REQ-021 Push when full without simultaneous pop: byte dropped, o_overrun pulses, FIFO contents unchanged.
REQ-022 Push and pop same cycle when full: pop completes, push accepted, count unchanged, no overrun.
REQ-023 Push and pop same cycle when count=1: new byte becomes head next cycle, o_rx_valid stays 1.
REQ-024 i_rx_ready while o_rx_valid=0: no effect.
REQ-025 Error pulses are exactly one clk_i cycle and never assert in the same cycle as a push of the erroneous byte.

Reset
REQ-026 reset_n low: FSM -> IDLE, counters 0, FIFO empty, synchronizer flops 1.
REQ-027 Reset outputs: o_rx_valid=0, o_rx_data=8'h00, o_frame_err=0, o_overrun=0, o_parity_err=0.
REQ-028 Reset mid-frame aborts the frame; after release, a line held low shall not start a frame until a high-to-low edge is seen.

Configuration
REQ-029 Macro UART_RX_PARITY_EN: defined -> PARITY state samples one even-parity bit after bit 7, then STOP.
REQ-030 With UART_RX_PARITY_EN, mismatch -> o_parity_err pulse at STOP sample, byte discarded even if stop is valid; frame error takes priority when both occur (only o_frame_err pulses).
REQ-031 Without UART_RX_PARITY_EN: 8N1 frames only, no PARITY state, o_parity_err constant 0.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-032 Send 8'hA5 8N1, i_rx_ready=0 -> o_rx_valid=1 one cycle after stop sample, o_rx_data=8'hA5, no error pulses.
REQ-033 Line low for 6 clocks then high -> false start, FSM back to IDLE, no push, no flags; next frame 8'h3C received correctly.
REQ-034 Send 8'h55 with stop bit low, line low 40 bits -> one o_frame_err pulse, nothing pushed; after line high, 8'h01 received.
REQ-035 Send 5 bytes 8'h10..8'h14 back-to-back, i_rx_ready=0 -> FIFO holds 10..13, one o_overrun on the 5th; then pop 4 in order 10,11,12,13.
REQ-036 FIFO full, pop asserted exactly in push cycle of 8'h77 -> no overrun, 8'h77 read last after 3 older bytes.
REQ-037 UART_RX_PARITY_EN: 8'h07 with parity 0 (wrong) -> o_parity_err pulse, no push; with parity 1 -> byte pushed; reset asserted at DATA bit 3 -> all outputs at reset values, next frame clean.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if -- receive-side byte stream between uart_rx and its consumer.
//   o_rx_data  : byte at the receive FIFO head (driven by uart_rx)
//   o_rx_valid : FIFO non-empty (driven by uart_rx)
//   i_rx_ready : consumer pop request (driven by the consumer)
// master = uart_rx (byte producer), slave = consumer.
`timescale 1ns/1ps
interface uart_rx_if;
   logic [7:0] o_rx_data;
   logic       o_rx_valid;
   logic       i_rx_ready;

   modport master (output o_rx_data, output o_rx_valid, input  i_rx_ready);
   modport slave  (input  o_rx_data, input  o_rx_valid, output i_rx_ready);
endinterface

// File: rtl/uart_rx.sv
// uart_rx -- 8-bit UART receiver with first-word-fall-through receive FIFO.
//   clk_i        : core clock, rising edge
//   reset_n      : asynchronous active-low reset
//   i_uart_rx    : serial line, asynchronous, idle high
//   rx_if        : byte stream (o_rx_data / o_rx_valid / i_rx_ready)
//   o_frame_err  : one-cycle pulse, stop bit sampled low (byte discarded)
//   o_overrun    : one-cycle pulse, completed byte dropped because FIFO full
//   o_parity_err : one-cycle pulse, even-parity mismatch (byte discarded)
// Build option: define UART_RX_PARITY_EN for 8E1 frames; default is 8N1 and
// o_parity_err is tied low.
`timescale 1ns/1ps
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic       clk_i,
   input  logic       reset_n,
   input  logic       i_uart_rx,
   uart_rx_if.master  rx_if,
   output logic       o_frame_err,
   output logic       o_overrun,
   output logic       o_parity_err
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);
   localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP, S_BREAK
   } state_t;

   logic          r_sync1, r_sync2, r_prev;
   logic [1:0]    r_warm;
   state_t        r_state;
   logic [15:0]   r_clk_cnt;
   logic [2:0]    r_bit_cnt;
   logic [7:0]    r_shift;
   logic          r_frame_err, r_overrun;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0] r_count;

   logic w_fall, w_stop_tick, w_par_ok, w_push, w_full, w_pop, w_wr;

   // r_warm marks when r_sync2 carries a real line sample instead of its
   // reset value; until then r_prev stays 0 so a line held low through
   // reset release is not mistaken for a start edge.
   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_warm  <= '0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= i_uart_rx;
         r_sync2 <= r_sync1;
         r_warm  <= {r_warm[0], 1'b1};
         r_prev  <= r_warm[1] & r_sync2;
      end
   end

   assign w_fall      = r_prev & ~r_sync2;
   assign w_stop_tick = (r_state == S_STOP) && (r_clk_cnt == LAST);

`ifdef UART_RX_PARITY_EN
   logic r_par_bit, r_parity_err;
   assign w_par_ok     = ~(^r_shift ^ r_par_bit);
   assign o_parity_err = r_parity_err;
`else
   assign w_par_ok     = 1'b1;
   assign o_parity_err = 1'b0;
`endif

   assign w_push = w_stop_tick & r_sync2 & w_par_ok;
   assign w_full = (r_count == CW'(FIFO_DEPTH));
   assign w_pop  = (r_count != '0) & rx_if.i_rx_ready;
   // A full FIFO still accepts the push when the head leaves the same cycle.
   assign w_wr   = w_push & (~w_full | w_pop);

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_clk_cnt   <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bit    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (w_fall) begin
                  r_state   <= S_START;
                  r_clk_cnt <= '0;
                  r_bit_cnt <= '0;
               end
            end
            S_START: begin
               if (r_clk_cnt == HALF) begin
                  r_clk_cnt <= '0;
                  r_state   <= r_sync2 ? S_IDLE : S_DATA;
               end else begin
                  r_clk_cnt <= r_clk_cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (r_clk_cnt == LAST) begin
                  r_clk_cnt <= '0;
                  r_shift   <= {r_sync2, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= S_PARITY;
`else
                     r_state <= S_STOP;
`endif
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 16'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (r_clk_cnt == LAST) begin
                  r_clk_cnt <= '0;
                  r_par_bit <= r_sync2;
                  r_state   <= S_STOP;
               end else begin
                  r_clk_cnt <= r_clk_cnt + 16'd1;
               end
            end
`endif
            S_STOP: begin
               if (r_clk_cnt == LAST) begin
                  r_clk_cnt <= '0;
                  if (!r_sync2) begin
                     // Frame error wins over parity error.
                     r_frame_err <= 1'b1;
                     r_state     <= S_BREAK;
                  end else begin
`ifdef UART_RX_PARITY_EN
                     r_parity_err <= ~w_par_ok;
`endif
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 16'd1;
               end
            end
            S_BREAK: begin
               if (r_sync2) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= w_push & w_full & ~w_pop;
         if (w_wr)  r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count <= r_count + CW'(w_wr) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_wr) r_mem[r_wr_ptr] <= r_shift;
   end

   assign rx_if.o_rx_valid = (r_count != '0);
   assign rx_if.o_rx_data  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
   assign o_frame_err      = r_frame_err;
   assign o_overrun        = r_overrun;

endmodule
